// File: rtl/axi4_lite_pkg.sv
// Shared definitions for the AXI4-Lite SFP master engine: FSM encoding,
// response codes and the fixed protection value driven on AWPROT/ARPROT.
package axi4_lite_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WR_ADDR_DATA = 3'd1,
    ST_WR_RESP      = 3'd2,
    ST_RD_ADDR      = 3'd3,
    ST_RD_DATA      = 3'd4,
    ST_DONE         = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Unprivileged, secure, data access.
  localparam logic [2:0] AXI_PROT = 3'b000;

  // Width of the bus timeout counter; holds any limit up to 65535.
  localparam int TIMEOUT_CNT_W = 16;

endpackage

// File: rtl/axi_timeout_cnt.sv
// Saturating busy-cycle counter. expire_o flags the cycle whose closing edge
// brings the count to LIMIT (and every enabled cycle after that), so the
// owner can abort on the same edge the limit is reached.
module axi_timeout_cnt
  import axi4_lite_pkg::*;
#(
  parameter int LIMIT = 1023
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [TIMEOUT_CNT_W-1:0] LIMIT_C = TIMEOUT_CNT_W'(LIMIT);
  localparam logic [TIMEOUT_CNT_W-1:0] LAST_C  = TIMEOUT_CNT_W'(LIMIT - 1);

  logic [TIMEOUT_CNT_W-1:0] cnt_q;
  logic [TIMEOUT_CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise count enabled cycles up to LIMIT.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q >= LAST_C);

endmodule

// File: rtl/axi4_lite_sfp_master.sv
// AXI4-Lite master engine: turns one request word into one AXI4-Lite
// transaction and returns a single-cycle response, with a bus timeout.
//
// Handshake semantics: a transfer happens on a rising clock edge where the
// channel's VALID and READY are both high. VALID is raised without waiting
// for READY and, with its payload, is held stable until that edge; the
// only exceptions are the timeout abort and reset. The request side follows
// the same rule with i_req_valid / o_req_ready.
module axi4_lite_sfp_master
  import axi4_lite_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 7,
  parameter int TIMEOUT_CYCLES     = 1023
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  // Request / response side
  input  logic                            i_req_valid,
  input  logic                            i_req_wr,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   i_req_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   i_req_data,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] i_req_strb,
  output logic                            o_req_ready,
  output logic                            o_rsp_valid,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   o_rsp_data,
  output logic [1:0]                      o_rsp_resp,
  output logic                            o_rsp_timeout,
  output logic [2:0]                      o_dbg_state,
  // Write address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  // Write data channel
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  // Write response channel
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  // Read address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  // Read data channel
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int SW = C_M_AXI_DATA_WIDTH / 8;

  state_e          state_q,       state_d;
  logic [AW-1:0]   addr_q,        addr_d;
  logic [DW-1:0]   data_q,        data_d;
  logic [SW-1:0]   strb_q,        strb_d;
  logic            awvalid_q,     awvalid_d;
  logic            wvalid_q,      wvalid_d;
  logic            bready_q,      bready_d;
  logic            arvalid_q,     arvalid_d;
  logic            rready_q,      rready_d;
  logic            rsp_valid_q,   rsp_valid_d;
  logic [DW-1:0]   rsp_data_q,    rsp_data_d;
  logic [1:0]      rsp_resp_q,    rsp_resp_d;
  logic            rsp_timeout_q, rsp_timeout_d;

  logic cnt_clear;
  logic cnt_en;
  logic cnt_expire;
  logic aw_hs;
  logic w_hs;
  logic aw_done;
  logic w_done;
  logic abort;

  // Word-aligned bus addresses ignore the two byte-offset bits.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^i_req_addr[1:0];

  axi_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (M_AXI_ACLK),
    .rst_ni   (M_AXI_ARESETN),
    .clear_i  (cnt_clear),
    .en_i     (cnt_en),
    .expire_o (cnt_expire)
  );

  assign aw_hs   = awvalid_q && M_AXI_AWREADY;
  assign w_hs    = wvalid_q  && M_AXI_WREADY;
  assign aw_done = !awvalid_q || aw_hs;
  assign w_done  = !wvalid_q  || w_hs;

  // Next-state and next-output logic; a completing handshake always beats
  // a timeout that expires on the same edge.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    data_d        = data_q;
    strb_d        = strb_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    rsp_valid_d   = 1'b0;
    rsp_data_d    = rsp_data_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_clear     = 1'b0;
    cnt_en        = 1'b0;
    abort         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_req_valid) begin
          cnt_clear = 1'b1;
          addr_d    = {i_req_addr[AW-1:2], 2'b00};
          data_d    = i_req_data;
          strb_d    = i_req_strb;
          if (i_req_wr) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR_ADDR_DATA;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RD_ADDR;
          end
        end
      end

      ST_WR_ADDR_DATA: begin
        cnt_en = 1'b1;
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end else if (cnt_expire) begin
          abort = 1'b1;
        end
      end

      ST_WR_RESP: begin
        cnt_en = 1'b1;
        if (M_AXI_BVALID) begin
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_data_d    = '0;
          rsp_resp_d    = M_AXI_BRESP;
          rsp_timeout_d = 1'b0;
          state_d       = ST_DONE;
        end else if (cnt_expire) begin
          abort = 1'b1;
        end
      end

      ST_RD_ADDR: begin
        cnt_en = 1'b1;
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_DATA;
        end else if (cnt_expire) begin
          abort = 1'b1;
        end
      end

      ST_RD_DATA: begin
        cnt_en = 1'b1;
        if (M_AXI_RVALID) begin
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_data_d    = M_AXI_RDATA;
          rsp_resp_d    = M_AXI_RRESP;
          rsp_timeout_d = 1'b0;
          state_d       = ST_DONE;
        end else if (cnt_expire) begin
          abort = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Dead-slave escape: drop every handshake line and report SLVERR.
    if (abort) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_data_d    = '0;
      rsp_resp_d    = RESP_SLVERR;
      rsp_timeout_d = 1'b1;
      state_d       = ST_DONE;
    end
  end

  // State and output registers; reset forces the idle, quiet bus.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      data_q        <= '0;
      strb_q        <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_resp_q    <= RESP_OKAY;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      strb_q        <= strb_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign o_req_ready   = (state_q == ST_IDLE);
  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_data    = rsp_data_q;
  assign o_rsp_resp    = rsp_resp_q;
  assign o_rsp_timeout = rsp_timeout_q;
  assign o_dbg_state   = state_q;

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = AXI_PROT;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = data_q;
  assign M_AXI_WSTRB   = strb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = AXI_PROT;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: doc/axi4_lite_sfp_master.md
Name: axi4_lite_sfp_master

Overview:
- AXI4-Lite master engine: the initiator end of the SFP control register interface.
- Turns a single-word request (address, data, strobe, read/write) into one complete AXI4-Lite transaction and returns the response.
- Bus-side ports mirror the SFP register slave, so the two connect port-to-port in simulation.
- Used by PL-side sequencers to program the SFP register bank without the PS, with a bus timeout so a hung slave cannot stall the sequencer.

Parameters:
- C_M_AXI_DATA_WIDTH, 32, AXI data width; must be 32.
- C_M_AXI_ADDR_WIDTH, 7, AXI byte-address width; 21 registers need $clog2(21)+2 = 7.
- TIMEOUT_CYCLES, 1023, number of busy cycles without completion before the transaction is aborted; range 2..65535.

Ports:
- M_AXI_ACLK  in  1  single clock.
- M_AXI_ARESETN  in  1  reset, asynchronous and active-low.
- i_req_valid  in  1  request present.
- i_req_wr  in  1  1 = write, 0 = read.
- i_req_addr  in  C_M_AXI_ADDR_WIDTH  byte address; bits [1:0] are forced to 0 on the bus.
- i_req_data  in  32  write data.
- i_req_strb  in  4  write byte strobes.
- o_req_ready  out  1  engine idle; request is accepted when i_req_valid && o_req_ready.
- o_rsp_valid  out  1  one-cycle completion pulse.
- o_rsp_data  out  32  read data; 0 for writes and timeouts.
- o_rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout.
- o_rsp_timeout  out  1  qualifies o_rsp_valid; 1 = aborted.
- M_AXI_AWADDR out ADDR_W; M_AXI_AWPROT out 3; M_AXI_AWVALID out 1; M_AXI_AWREADY in 1.
- M_AXI_WDATA out 32; M_AXI_WSTRB out 4; M_AXI_WVALID out 1; M_AXI_WREADY in 1.
- M_AXI_BRESP in 2; M_AXI_BVALID in 1; M_AXI_BREADY out 1.
- M_AXI_ARADDR out ADDR_W; M_AXI_ARPROT out 3; M_AXI_ARVALID out 1; M_AXI_ARREADY in 1.
- M_AXI_RDATA in 32; M_AXI_RRESP in 2; M_AXI_RVALID in 1; M_AXI_RREADY out 1.

Behaviour:
- Reset values:
  - o_req_ready = 1; every other output = 0.
  - AWPROT/ARPROT are constant 3'b000.
  - Address, data and strobe registers = 0.
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE:
  - o_req_ready = 1.
  - On accept, latch address/data/strobe and clear the timeout counter.
  - Write goes to WR_ADDR_DATA; read goes to RD_ADDR.
  - o_req_ready is low in every other state; requests presented then are ignored.
- WR_ADDR_DATA:
  - AWVALID and WVALID both assert in the first cycle after accept (the slave requires both together).
  - Each drops independently in the cycle after its own handshake (VALID && READY sampled).
  - When both handshakes are done (same cycle or different cycles), go to WR_RESP.
- WR_RESP:
  - BREADY = 1.
  - On BVALID, capture BRESP, deassert BREADY and go to DONE.
- RD_ADDR:
  - ARVALID = 1 until ARREADY is sampled, then go to RD_DATA.
- RD_DATA:
  - RREADY = 1.
  - On RVALID, capture RDATA/RRESP, deassert RREADY and go to DONE.
- DONE:
  - o_rsp_valid = 1 for exactly one cycle, with data/resp registered.
  - Return to IDLE; o_req_ready is high again the following cycle.
- Bus rules:
  - AWADDR/WDATA/WSTRB/ARADDR stay stable while the matching VALID is high.
  - VALID never waits on READY.
- Latency against the SFP register slave (awready/arready one cycle after valid): accept at cycle 0, o_rsp_valid at cycle 4, for both read and write.
- Timeout:
  - The counter increments every cycle in the four bus states and saturates.
  - Reaching TIMEOUT_CYCLES aborts: all VALID/READY outputs go to 0 the next cycle and the FSM goes to DONE.
  - The abort reports o_rsp_timeout = 1, o_rsp_resp = 2'b10, o_rsp_data = 0.
  - The abort is a deliberate protocol escape for a dead slave; the system must reset the slave afterwards.
- A completion handshake in the same cycle the count reaches TIMEOUT_CYCLES counts as success, not timeout.
- A non-OKAY BRESP/RRESP is passed through with o_rsp_timeout = 0.
- Reset asserted mid-transaction: all outputs return to reset values immediately (asynchronously), no response is produced, and the FSM returns to IDLE.

Decomposition:
- Shared package axi4_lite_pkg:
  - FSM state encoding.
  - AXI response constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - Common PROT value.
- One sub-module, axi_timeout_cnt: a saturating counter with clear/enable inputs and an expired flag. All other logic lives in a single module.

Test Plan:
- Write 0x0000_0001 to addr 0x00, strb 4'hF, against the SFP slave -> AW and W asserted together at cycle 1; o_rsp_valid at cycle 4 with resp 00, timeout 0; slave o_sfp_en = 1.
- Read addr 0x20 (reg 8) with i_m_sfp_rsp = 64'h1234_5678_9ABC_DEF0 -> o_rsp_data = 32'h9ABC_DEF0, resp 00.
- Behavioural slave gives WREADY 3 cycles after AWREADY, strb 4'h3, data 32'hDEAD_BEEF -> AWVALID drops after its handshake, WVALID holds stable until WREADY; slave register low half = 16'hBEEF.
- Slave never asserts ARREADY, TIMEOUT_CYCLES = 16 -> ARVALID drops after the 16th busy cycle; o_rsp_valid with timeout 1, resp 10, data 0; o_req_ready high again the next cycle.
- Slave returns BRESP = 2'b10 -> o_rsp_resp = 10, o_rsp_timeout = 0.
- M_AXI_ARESETN pulled low during RD_DATA -> RREADY = 0 and o_req_ready = 1 immediately, no o_rsp_valid; a fresh read after reset release completes normally.
